// File: rtl/ucsbece154b_gshare_bp.sv
// Branch predictor: tagged direct-mapped BTB plus a PHT of 2-bit counters with a speculative GHR.
// Define BP_GSHARE_EN for gshare indexing (pc XOR GHR); without it the predictor is bimodal and has no GHR.
module ucsbece154b_gshare_bp #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [31:0]             pc_i,
    input  logic                    fetch_en_i,
    output logic                    BranchTaken_o,
    output logic [31:0]             BTBtarget_o,
    output logic [NUM_GHR_BITS-1:0] PHTreadaddress_o,
    input  logic                    upd_en_i,
    input  logic [31:0]             upd_pc_i,
    input  logic [31:0]             upd_target_i,
    input  logic                    upd_is_jump_i,
    input  logic                    upd_taken_i,
    input  logic [NUM_GHR_BITS-1:0] upd_phtaddr_i,
    input  logic                    upd_mispredict_i
);

    localparam int BI    = $clog2(NUM_BTB_ENTRIES);
    localparam int TAG_W = 30 - BI;
    localparam int PHT_N = 1 << NUM_GHR_BITS;

    logic              btb_valid_reg  [NUM_BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_reg    [NUM_BTB_ENTRIES];
    logic [31:0]       btb_target_reg [NUM_BTB_ENTRIES];
    logic              btb_jump_reg   [NUM_BTB_ENTRIES];
    logic [1:0]        pht_reg        [PHT_N];

    logic [BI-1:0]           fetch_idx;
    logic [TAG_W-1:0]        fetch_tag;
    logic [NUM_GHR_BITS-1:0] pht_idx;
    logic                    hit;
    logic                    pred_dir;

    logic [BI-1:0]              upd_idx;
    logic [TAG_W-1:0]           upd_tag;
    logic                       btb_we;
    logic                       pht_we;
    logic [NUM_BTB_ENTRIES-1:0] btb_wsel;
    logic [1:0]                 pht_cur;
    logic [1:0]                 pht_next;

    // Fetch-side lookup is purely combinational; writes land on the edge, so no bypass exists.
    assign fetch_idx = pc_i[BI+1:2];
    assign fetch_tag = pc_i[31:BI+2];
    assign hit       = btb_valid_reg[fetch_idx] && (btb_tag_reg[fetch_idx] == fetch_tag);
    assign pred_dir  = pht_reg[pht_idx][1];

    assign BranchTaken_o    = hit && (btb_jump_reg[fetch_idx] || pred_dir);
    assign BTBtarget_o      = hit ? btb_target_reg[fetch_idx] : 32'd0;
    assign PHTreadaddress_o = pht_idx;

    assign upd_idx = upd_pc_i[BI+1:2];
    assign upd_tag = upd_pc_i[31:BI+2];
    assign btb_we  = upd_en_i && (upd_is_jump_i || upd_taken_i);
    assign pht_we  = upd_en_i && !upd_is_jump_i;
    assign pht_cur = pht_reg[upd_phtaddr_i];

    generate
        for (genvar gi = 0; gi < NUM_BTB_ENTRIES; gi++) begin : g_btb_wsel
            assign btb_wsel[gi] = btb_we && (upd_idx == BI'(gi));
        end
    endgenerate

    always_comb begin
        pht_next = pht_cur;
        if (upd_taken_i) begin
            if (pht_cur != 2'b11) pht_next = pht_cur + 2'b01;
        end else begin
            if (pht_cur != 2'b00) pht_next = pht_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) btb_valid_reg[i] <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                if (btb_wsel[i]) btb_valid_reg[i] <= 1'b1;
            end
        end
    end

    // Entry payload carries no reset: a cleared valid bit makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (reset_i && btb_we) begin
            btb_tag_reg[upd_idx]    <= upd_tag;
            btb_target_reg[upd_idx] <= upd_target_i;
            btb_jump_reg[upd_idx]   <= upd_is_jump_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            for (int i = 0; i < PHT_N; i++) pht_reg[i] <= 2'b01;
        end else if (pht_we) begin
            pht_reg[upd_phtaddr_i] <= pht_next;
        end
    end

`ifdef BP_GSHARE_EN
    logic [NUM_GHR_BITS-1:0] ghr_reg;
    logic [NUM_GHR_BITS-1:0] ghr_next;
    logic                    unused_bits;

    assign pht_idx     = pc_i[NUM_GHR_BITS+1:2] ^ ghr_reg;
    assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

    // A resolved mispredict flushes history and wins over the speculative shift.
    always_comb begin
        ghr_next = ghr_reg;
        if (upd_en_i && upd_mispredict_i) begin
            ghr_next = '0;
        end else if (fetch_en_i && hit && !btb_jump_reg[fetch_idx]) begin
            ghr_next = {ghr_reg[NUM_GHR_BITS-2:0], pred_dir};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) ghr_reg <= '0;
        else          ghr_reg <= ghr_next;
    end
`else
    logic unused_bits;

    assign pht_idx     = pc_i[NUM_GHR_BITS+1:2];
    assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0], fetch_en_i, upd_mispredict_i};
`endif

endmodule

// File: doc/ucsbece154b_gshare_bp.md
Name: ucsbece154b_gshare_bp

Overview:
Branch predictor responder for the 5-stage RISC-V pipeline. The datapath queries it every fetch cycle with PCF and gets a combinational taken/target prediction. The datapath updates it from the EX stage with resolved branch and jump outcomes. Internally it holds a tagged direct-mapped BTB, a PHT of 2-bit saturating counters, and a speculative global history register (GHR).

Parameters:
NUM_BTB_ENTRIES, 32, BTB entries; power of 2, 4..256.
NUM_GHR_BITS, 5, GHR width; PHT holds 2^NUM_GHR_BITS counters; 2..10.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset_i  in  1  synchronous, active-low reset (0 = reset).
pc_i  in  32  fetch-stage PC (PCF).
fetch_en_i  in  1  fetch advancing this cycle (~StallF); gates the speculative GHR shift.
BranchTaken_o  out  1  predict redirect to BTBtarget_o.
BTBtarget_o  out  32  predicted target; 0 when there is no BTB hit.
PHTreadaddress_o  out  NUM_GHR_BITS  PHT index used for this prediction; the datapath pipelines it to EX.
upd_en_i  in  1  EX has a resolved branch or jump this cycle.
upd_pc_i  in  32  PC of the resolving instruction (PCE).
upd_target_i  in  32  computed target (PCTargetE).
upd_is_jump_i  in  1  1 = jal/jalr, 0 = conditional branch.
upd_taken_i  in  1  actual direction.
upd_phtaddr_i  in  NUM_GHR_BITS  PHT index carried from fetch.
upd_mispredict_i  in  1  predicted direction/target differed from actual.

Behaviour:
- Index fields: BI = log2(NUM_BTB_ENTRIES).
  - BTB index = pc[BI+1:2]; tag = pc[31:BI+2].
  - Each BTB entry stores valid, tag, target[31:0] and is_jump.
- PHT index = pc[NUM_GHR_BITS+1:2] XOR GHR; it drives PHTreadaddress_o.
- Prediction is combinational from pc_i:
  - hit = valid & tag match.
  - BranchTaken_o = hit & (is_jump | PHT[idx][1]).
  - BTBtarget_o = hit ? target : 0.
- Speculative GHR: on a rising edge with fetch_en_i=1 and a hit on a branch entry (is_jump=0), GHR <= {GHR[NUM_GHR_BITS-2:0], PHT[idx][1]}. Otherwise GHR holds.
- Update, on an edge with upd_en_i=1:
  - BTB write occurs if upd_is_jump_i=1 or upd_taken_i=1. It writes the entry indexed by upd_pc_i with valid=1, tag, upd_target_i and upd_is_jump_i. A conflicting entry is overwritten.
  - A not-taken branch never allocates a BTB entry and never modifies an existing one.
  - If upd_is_jump_i=0: PHT[upd_phtaddr_i] increments when taken and decrements when not taken. Counters saturate at 3 and 0.
  - If upd_mispredict_i=1: GHR <= 0. This takes priority over the same-cycle speculative shift.
- Same-cycle read and write of the same BTB or PHT entry: the prediction uses the pre-write value. There is no bypass. The new value is visible the next cycle.
- Reset (reset_i=0 at an edge):
  - all BTB valid bits <= 0;
  - all PHT counters <= 2'b01 (weakly not-taken);
  - GHR <= 0.
  - Update and shift are both ignored that cycle.
  - In the cycle after reset: BranchTaken_o=0, BTBtarget_o=0, PHTreadaddress_o=pc_i[NUM_GHR_BITS+1:2].
- Reset asserted mid-stream discards all learned state; it is never partially applied.
- upd_en_i=0: the update, mispredict and phtaddr inputs are ignored.

Optional Feature:
BP_GSHARE_EN
- Defined: the PHT index is pc bits XOR GHR, as above.
- Undefined: bimodal predictor.
  - PHT index = pc[NUM_GHR_BITS+1:2].
  - The GHR register is removed.
  - upd_mispredict_i and fetch_en_i are ignored.
  - Ports are unchanged.

Test Plan:
- Reset with pc_i=0x100 -> BranchTaken_o=0, BTBtarget_o=0, PHTreadaddress_o=0x00 (GHR=0); all subsequent PCs miss until the first update.
- Update jal at 0x100 (target 0x200, is_jump=1, taken=1); next cycle pc_i=0x100 -> BranchTaken_o=1, BTBtarget_o=0x200; GHR unchanged when fetch_en_i=1.
- Branch at 0x40 (target 0x20), idx 0x10: update taken twice -> counter 01->10->11, BranchTaken_o=1; update not-taken three times -> 11->10->01->00 with saturation at 00, BranchTaken_o=0, BTB entry still valid.
- Same-cycle collision: pc_i=0x40 with an update at 0x40 -> outputs reflect the old counter that cycle and the new counter the next cycle.
- GSHARE: hit on a taken-predicted branch with fetch_en_i=1 shifts GHR 00000->00001; the same with fetch_en_i=0 leaves it unchanged; upd_mispredict_i=1 coincident with a shift -> GHR=0.
- Tag conflict with NUM_BTB_ENTRIES=32: taken update at 0x040 then taken update at 0x0C0 (same index) -> pc_i=0x040 misses, pc_i=0x0C0 hits.
